// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module : cpu_types (package)
// Desc   : Shared CPU types: RS tags, CDB bundle, CDB sizing, RR helper.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types;

    typedef enum logic [3:0] {
        INVALID = 4'd0,
        ALU_RS0, ALU_RS1, ALU_RS2, ALU_RS3,
        MUL_RS0, MUL_RS1, MUL_RS2,
        LD_RS0,  LD_RS1,  LD_RS2,
        ST_RS0,  ST_RS1,  ST_RS2,
        BR_RS0,  BR_RS1
    } RS_tag_type;

    localparam int CDB_NUM_FU = 4;
    localparam int CDB_XLEN   = 32;

    typedef struct packed {
        logic                valid;
        RS_tag_type          tag;
        logic [CDB_XLEN-1:0] val;
    } cdb_t;

    function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Desc   : Combinational round-robin selector: first request at/after pointer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit so the modulo wrap works for non-power-of-two N
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Desc   : Per-FU result holding slots, round-robin grant onto registered CDB.
//          Optional same-cycle bypass into the CDB regs: define CDB_BYPASS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cpu_types::*;
#(
    parameter int NUM_FU = 4,
    parameter int XLEN   = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic       [NUM_FU-1:0]        FU_valid,
    input  RS_tag_type [NUM_FU-1:0]        FU_tag,
    input  logic       [NUM_FU-1:0][XLEN-1:0] FU_val,
    output logic       [NUM_FU-1:0]        FU_ready,
    output logic                           CDB_valid,
    output RS_tag_type                     CDB_tag,
    output logic       [XLEN-1:0]          CDB_val,
    output logic       [$clog2(NUM_FU)-1:0] CDB_src
);
    localparam int IW = $clog2(NUM_FU);

    logic       [NUM_FU-1:0]           r_hold_valid;
    RS_tag_type [NUM_FU-1:0]           r_hold_tag;
    logic       [NUM_FU-1:0][XLEN-1:0] r_hold_val;
    logic       [IW-1:0]               r_rr_ptr;
    logic                              r_cdb_valid;
    RS_tag_type                        r_cdb_tag;
    logic       [XLEN-1:0]             r_cdb_val;
    logic       [IW-1:0]               r_cdb_src;

    logic [NUM_FU-1:0] w_store;
    logic [NUM_FU-1:0] w_hold_grant;
    logic [IW-1:0]     w_hold_idx;
    logic              w_hold_any;
    logic [NUM_FU-1:0] w_byp_grant;
    logic [IW-1:0]     w_byp_idx;
    logic              w_byp_any;

    // INVALID-tagged results complete the handshake but are never kept
    always_comb begin
        w_store = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_store[i] = FU_valid[i] & ~r_hold_valid[i] & (FU_tag[i] != INVALID);
        end
    end

    rr_arbiter #(.N(NUM_FU)) u_hold_arb (
        .i_req   (r_hold_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_hold_grant),
        .o_idx   (w_hold_idx),
        .o_any   (w_hold_any)
    );

`ifdef CDB_BYPASS_EN
    logic [NUM_FU-1:0] w_byp_grant_raw;
    logic              w_byp_req;

    rr_arbiter #(.N(NUM_FU)) u_byp_arb (
        .i_req   (w_store),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_byp_grant_raw),
        .o_idx   (w_byp_idx),
        .o_any   (w_byp_req)
    );

    assign w_byp_any   = w_byp_req & ~w_hold_any;
    assign w_byp_grant = w_byp_any ? w_byp_grant_raw : '0;
`else
    assign w_byp_any   = 1'b0;
    assign w_byp_grant = '0;
    assign w_byp_idx   = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_hold_valid <= '0;
            for (int i = 0; i < NUM_FU; i++) begin
                r_hold_tag[i] <= INVALID;
                r_hold_val[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= INVALID;
            r_cdb_val   <= '0;
            r_cdb_src   <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (w_hold_grant[i]) begin
                    r_hold_valid[i] <= 1'b0;
                end else if (w_store[i] && !w_byp_grant[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_tag[i]   <= FU_tag[i];
                    r_hold_val[i]   <= FU_val[i];
                end
            end
            if (w_hold_any) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= r_hold_tag[w_hold_idx];
                r_cdb_val   <= r_hold_val[w_hold_idx];
                r_cdb_src   <= w_hold_idx;
                r_rr_ptr    <= IW'(rr_inc(32'(w_hold_idx), 32'(NUM_FU)));
            end else if (w_byp_any) begin
                r_cdb_valid <= 1'b1;
                r_cdb_tag   <= FU_tag[w_byp_idx];
                r_cdb_val   <= FU_val[w_byp_idx];
                r_cdb_src   <= w_byp_idx;
                r_rr_ptr    <= IW'(rr_inc(32'(w_byp_idx), 32'(NUM_FU)));
            end else begin
                r_cdb_valid <= 1'b0;
                r_cdb_tag   <= INVALID;
                r_cdb_val   <= '0;
            end
        end
    end

    assign FU_ready  = ~r_hold_valid;
    assign CDB_valid = r_cdb_valid;
    assign CDB_tag   = r_cdb_tag;
    assign CDB_val   = r_cdb_val;
    assign CDB_src   = r_cdb_src;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Desc   : Directed + random stimulus against a slot/pointer reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cpu_types::*;

    localparam int N = CDB_NUM_FU;
    localparam int W = CDB_XLEN;

    logic                       CLK = 1'b0;
    logic                       RST = 1'b1;
    logic       [N-1:0]         FU_valid;
    RS_tag_type [N-1:0]         FU_tag;
    logic       [N-1:0][W-1:0]  FU_val;
    logic       [N-1:0]         FU_ready;
    logic                       CDB_valid;
    RS_tag_type                 CDB_tag;
    logic       [W-1:0]         CDB_val;
    logic       [$clog2(N)-1:0] CDB_src;

    cdb_arbiter #(.NUM_FU(N), .XLEN(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .FU_valid  (FU_valid),
        .FU_tag    (FU_tag),
        .FU_val    (FU_val),
        .FU_ready  (FU_ready),
        .CDB_valid (CDB_valid),
        .CDB_tag   (CDB_tag),
        .CDB_val   (CDB_val),
        .CDB_src   (CDB_src)
    );

    always #5 CLK = ~CLK;

    // Reference: one slot per FU, a rotating start point, expected broadcast
    bit         m_full[N];
    RS_tag_type m_tag[N];
    logic [W-1:0] m_val[N];
    int         m_ptr;
    cdb_t       exp_cdb;
    int         exp_src;

    // Per-FU pending results; the head is presented until accepted
    RS_tag_type   q_tag[N][$];
    logic [W-1:0] q_val[N][$];

    int n_vec;
    int n_bad;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 1'b0;
            m_tag[i]  = INVALID;
            m_val[i]  = '0;
        end
        m_ptr   = 0;
        exp_cdb = '{valid: 1'b0, tag: INVALID, val: '0};
        exp_src = 0;
    endtask

    task automatic model_step();
        bit xfer[N];
        int win;
        int byp;
        int j;
        for (int i = 0; i < N; i++) xfer[i] = FU_valid[i] && !m_full[i];
        win = -1;
        byp = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (win < 0 && m_full[j]) win = j;
        end
        exp_cdb = '{valid: 1'b0, tag: INVALID, val: '0};
        if (win >= 0) begin
            exp_cdb = '{valid: 1'b1, tag: m_tag[win], val: m_val[win]};
            exp_src = win;
            m_full[win] = 1'b0;
            m_ptr = (win + 1) % N;
        end
`ifdef CDB_BYPASS_EN
        else begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (byp < 0 && xfer[j] && FU_tag[j] != INVALID) byp = j;
            end
            if (byp >= 0) begin
                exp_cdb = '{valid: 1'b1, tag: FU_tag[byp], val: FU_val[byp]};
                exp_src = byp;
                m_ptr = (byp + 1) % N;
            end
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                if (FU_tag[i] != INVALID && i != byp) begin
                    m_full[i] = 1'b1;
                    m_tag[i]  = FU_tag[i];
                    m_val[i]  = FU_val[i];
                end
                void'(q_tag[i].pop_front());
                void'(q_val[i].pop_front());
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) er[i] = !m_full[i];
        chk("FU_ready", 64'(FU_ready), 64'(er));
        chk("CDB_valid", 64'(CDB_valid), 64'(exp_cdb.valid));
        chk("CDB_tag", 64'(CDB_tag), 64'(exp_cdb.tag));
        chk("CDB_val", 64'(CDB_val), 64'(exp_cdb.val));
        if (exp_cdb.valid) chk("CDB_src", 64'(CDB_src), 64'(exp_src));
    endtask

    task automatic push(input int fu, input RS_tag_type tag, input logic [W-1:0] val);
        q_tag[fu].push_back(tag);
        q_val[fu].push_back(val);
    endtask

    // Called just after a falling edge: present heads, advance model, check
    task automatic tick();
        for (int i = 0; i < N; i++) begin
            if (q_tag[i].size() != 0) begin
                FU_valid[i] = 1'b1;
                FU_tag[i]   = q_tag[i][0];
                FU_val[i]   = q_val[i][0];
            end else begin
                FU_valid[i] = 1'b0;
                FU_tag[i]   = INVALID;
                FU_val[i]   = '0;
            end
        end
        model_step();
        @(posedge CLK);
        #1;
        check_outputs();
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        FU_valid = '0;
        FU_val   = '0;
        for (int i = 0; i < N; i++) FU_tag[i] = INVALID;
        model_reset();

        // Reset state
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check_outputs();
        chk("CDB_src_rst", 64'(CDB_src), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();

        // Single result from FU2
        push(2, ALU_RS1, 32'hDEADBEEF);
        ticks(3);

        // Wrap: pointer now at 3 with FU0 and FU3 arriving together
        push(0, MUL_RS0, 32'h0000_0A0A);
        push(3, LD_RS2,  32'h0000_3B3B);
        ticks(3);
        // Lone FU3 result returns the pointer to 0
        push(3, ST_RS0, 32'h1357_9BDF);
        ticks(2);

        // All four FUs at once
        for (int i = 0; i < N; i++) push(i, RS_tag_type'(4'(i + 5)), 32'hC0DE_0000 + 32'(i));
        ticks(6);

        // Back-to-back stream from FU1
        for (int k = 0; k < 6; k++) push(1, RS_tag_type'(4'(k + 1)), 32'h111 * 32'(k + 1));
        ticks(14);

        // INVALID-tag result is accepted and dropped
        push(0, INVALID, 32'h0000_1234);
        ticks(3);

        // Random traffic, INVALID tags included
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (q_tag[i].size() == 0 && $urandom_range(0, 2) == 0) begin
                    push(i, RS_tag_type'(4'($urandom_range(0, 15))), $urandom);
                end
            end
            tick();
        end
        ticks(8);

        // Reset mid-operation with slots full
        for (int i = 0; i < N; i++) push(i, RS_tag_type'(4'(i + 9)), 32'hFACE_0000 + 32'(i));
        tick();
        #2;
        RST = 1'b1;
        #1;
        chk("rst_CDB_valid", 64'(CDB_valid), 64'd0);
        chk("rst_CDB_tag", 64'(CDB_tag), 64'(INVALID));
        chk("rst_CDB_val", 64'(CDB_val), 64'd0);
        chk("rst_FU_ready", 64'(FU_ready), 64'({N{1'b1}}));
        for (int i = 0; i < N; i++) begin
            q_tag[i].delete();
            q_val[i].delete();
        end
        FU_valid = '0;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
